// File: rtl/rx_parser_pkg.sv
// Shared state type, header byte offsets and small helpers for rx_segment_parser.
package rx_parser_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StSkip
    } state_e;

    localparam logic [15:0] DEFAULT_ETHERTYPE = 16'h88B5;

    localparam logic [7:0] ETYPE_OFS  = 8'd12;
    localparam logic [7:0] SEG_OFS    = 8'd14;
    localparam logic [7:0] SEGMAX_OFS = 8'd16;
    localparam logic [7:0] AUX_OFS    = 8'd18;
    localparam logic [7:0] HDR_LAST   = 8'd19;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Byte idx (0 = first on the wire) of a big-endian MAC; 0 outside 0..5.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [7:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < 6; k++) begin
            if (idx == 8'(k)) b = mac[8*(5-k) +: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/rx_segment_parser_mac_filter.sv
// Destination MAC filter: tracks bytes 0-5 against LOCAL_MAC and broadcast.
// Only built when DEST_MAC_FILTER_EN is defined.
`ifdef DEST_MAC_FILTER_EN
module mac_filter
    import rx_parser_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_en,
    input  logic [7:0] byte_idx,
    input  logic [7:0] data,
    output logic       match
);

    logic local_q, local_d;
    logic bcast_q, bcast_d;
    logic hit_local, hit_bcast;

    always_comb begin
        local_d   = local_q;
        bcast_d   = bcast_q;
        hit_local = (data == mac_byte(LOCAL_MAC, byte_idx));
        hit_bcast = (data == 8'hFF);
        if (byte_en) begin
            if (byte_idx == 8'd0) begin
                local_d = hit_local;
                bcast_d = hit_bcast;
            end else if (byte_idx < 8'd6) begin
                local_d = local_q & hit_local;
                bcast_d = bcast_q & hit_bcast;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            local_q <= 1'b0;
            bcast_q <= 1'b0;
        end else begin
            local_q <= local_d;
            bcast_q <= bcast_d;
        end
    end

    assign match = local_q | bcast_q;

endmodule
`endif

// File: rtl/rx_segment_parser.sv
// Parses test-frame headers: checks EtherType, extracts segment fields, counts frames.
// Define DEST_MAC_FILTER_EN to also require dst MAC == LOCAL_MAC or broadcast.
module rx_segment_parser
    import rx_parser_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE = DEFAULT_ETHERTYPE,
    parameter int unsigned AUX_BITS  = 12,
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [15:0]         segment_number,
    output logic [15:0]         segment_number_max,
    output logic [AUX_BITS:0]   aux,
    output logic                valid_out,
    output logic [15:0]         frame_count,
    output logic [15:0]         drop_count
);

    localparam logic [7:0] ETYPE_LO   = ETYPE_OFS + 8'd1;
    localparam logic [7:0] SEG_LO     = SEG_OFS + 8'd1;
    localparam logic [7:0] SEGMAX_LO  = SEGMAX_OFS + 8'd1;

    state_e             state_q, state_d;
    logic [7:0]         idx_q, idx_d;
    logic               rx_valid_q;
    logic               etype_hi_ok_q, etype_hi_ok_d;
    logic [15:0]        seg_sh_q, seg_sh_d;
    logic [15:0]        max_sh_q, max_sh_d;
    logic [7:0]         aux_hi_q, aux_hi_d;
    logic [15:0]        seg_q, seg_d;
    logic [15:0]        segmax_q, segmax_d;
    logic [AUX_BITS:0]  aux_q, aux_d;
    logic               valid_q, valid_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic [15:0]        aux_full;
    logic               start;
    logic               mac_ok;

    assign start = (state_q == StIdle) && rx_valid && !rx_valid_q;

`ifdef DEST_MAC_FILTER_EN
    logic       byte_en;
    logic [7:0] cur_idx;

    assign byte_en = start || ((state_q == StHeader) && rx_valid);
    assign cur_idx = start ? 8'd0 : idx_q;

    mac_filter #(
        .LOCAL_MAC (LOCAL_MAC)
    ) u_mac_filter (
        .clk      (clk),
        .rst      (rst),
        .byte_en  (byte_en),
        .byte_idx (cur_idx),
        .data     (rx_data),
        .match    (mac_ok)
    );
`else
    logic unused_local_mac;
    assign unused_local_mac = ^LOCAL_MAC;
    assign mac_ok = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        etype_hi_ok_d = etype_hi_ok_q;
        seg_sh_d      = seg_sh_q;
        max_sh_d      = max_sh_q;
        aux_hi_d      = aux_hi_q;
        seg_d         = seg_q;
        segmax_d      = segmax_q;
        aux_d         = aux_q;
        valid_d       = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        aux_full      = {aux_hi_q, rx_data};

        unique case (state_q)
            StIdle: begin
                idx_d = 8'd0;
                if (start) begin
                    state_d = StHeader;
                    idx_d   = 8'd1;
                end else if (rx_valid) begin
                    // Line was already busy (e.g. reset released mid-frame).
                    state_d = StSkip;
                end
            end
            StHeader: begin
                if (!rx_valid) begin
                    state_d    = StIdle;
                    drop_cnt_d = sat_inc16(drop_cnt_q);
                end else begin
                    idx_d = idx_q + 8'd1;
                    case (idx_q)
                        ETYPE_OFS: etype_hi_ok_d = (rx_data == ETHERTYPE[15:8]);
                        ETYPE_LO: begin
                            if (!(etype_hi_ok_q && (rx_data == ETHERTYPE[7:0]) && mac_ok)) begin
                                state_d    = StSkip;
                                drop_cnt_d = sat_inc16(drop_cnt_q);
                            end
                        end
                        SEG_OFS:    seg_sh_d[15:8] = rx_data;
                        SEG_LO:     seg_sh_d[7:0]  = rx_data;
                        SEGMAX_OFS: max_sh_d[15:8] = rx_data;
                        SEGMAX_LO:  max_sh_d[7:0]  = rx_data;
                        AUX_OFS:    aux_hi_d       = rx_data;
                        HDR_LAST: begin
                            seg_d       = seg_sh_q;
                            segmax_d    = max_sh_q;
                            aux_d       = aux_full[AUX_BITS:0];
                            valid_d     = 1'b1;
                            frame_cnt_d = sat_inc16(frame_cnt_q);
                            state_d     = StSkip;
                        end
                        default: ;
                    endcase
                end
            end
            StSkip: begin
                if (!rx_valid) begin
                    state_d = StIdle;
                    idx_d   = 8'd0;
                end else if (idx_q != 8'hFF) begin
                    idx_d = idx_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            idx_q         <= 8'd0;
            rx_valid_q    <= 1'b1;
            etype_hi_ok_q <= 1'b0;
            seg_sh_q      <= 16'd0;
            max_sh_q      <= 16'd0;
            aux_hi_q      <= 8'd0;
            seg_q         <= 16'd0;
            segmax_q      <= 16'd0;
            aux_q         <= '0;
            valid_q       <= 1'b0;
            frame_cnt_q   <= 16'd0;
            drop_cnt_q    <= 16'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            rx_valid_q    <= rx_valid;
            etype_hi_ok_q <= etype_hi_ok_d;
            seg_sh_q      <= seg_sh_d;
            max_sh_q      <= max_sh_d;
            aux_hi_q      <= aux_hi_d;
            seg_q         <= seg_d;
            segmax_q      <= segmax_d;
            aux_q         <= aux_d;
            valid_q       <= valid_d;
            frame_cnt_q   <= frame_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign segment_number     = seg_q;
    assign segment_number_max = segmax_q;
    assign aux                = aux_q;
    assign valid_out          = valid_q;
    assign frame_count        = frame_cnt_q;
    assign drop_count         = drop_cnt_q;

endmodule

// File: tb/tb_rx_segment_parser.sv
// Randomized frame-level bench for rx_segment_parser against a per-frame reference model.
// Honours DEST_MAC_FILTER_EN when the design is built with it.
module tb_rx_segment_parser;

    localparam logic [15:0] ETYPE  = 16'h88B5;
    localparam int unsigned AUXB   = 12;
    localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [15:0]   segment_number, segment_number_max, frame_count, drop_count;
    logic [AUXB:0] aux;
    logic          valid_out;

    int            n_checks = 0;
    int            n_fail = 0;
    int            exp_frames = 0;
    int            exp_drops = 0;
    logic [15:0]   exp_seg = '0;
    logic [15:0]   exp_max = '0;
    logic [AUXB:0] exp_aux = '0;
    logic [7:0]    frm[$];

    always #5 clk = ~clk;

    rx_segment_parser #(
        .ETHERTYPE (ETYPE),
        .AUX_BITS  (AUXB),
        .LOCAL_MAC (MY_MAC)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .segment_number     (segment_number),
        .segment_number_max (segment_number_max),
        .aux                (aux),
        .valid_out          (valid_out),
        .frame_count        (frame_count),
        .drop_count         (drop_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic build_frame(input int len, input logic [15:0] etype, input logic [47:0] dst,
                               input logic [15:0] seg, input logic [15:0] smax,
                               input logic [15:0] aux16);
        logic [7:0] hdr [20];
        for (int i = 0; i < 20; i++) hdr[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) hdr[i] = dst[8*(5-i) +: 8];
        hdr[12] = etype[15:8];  hdr[13] = etype[7:0];
        hdr[14] = seg[15:8];    hdr[15] = seg[7:0];
        hdr[16] = smax[15:8];   hdr[17] = smax[7:0];
        hdr[18] = aux16[15:8];  hdr[19] = aux16[7:0];
        frm.delete();
        for (int i = 0; i < len; i++) frm.push_back(i < 20 ? hdr[i] : 8'($urandom));
    endtask

    // A frame is kept iff it carries a full 20-byte header with the right type (and dst).
    function automatic bit model_accepts();
        bit ok;
        if (frm.size() < 20) return 1'b0;
        ok = ({frm[12], frm[13]} == ETYPE);
`ifdef DEST_MAC_FILTER_EN
        begin
            logic [47:0] dst;
            dst = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
            ok = ok && ((dst == MY_MAC) || (dst == BCAST));
        end
`endif
        return ok;
    endfunction

    function automatic logic [15:0] sat16(input int v);
        return (v > 16'hFFFF) ? 16'hFFFF : 16'(v);
    endfunction

    // Drives frm, then `gap` idle cycles; optional reset window by byte index (-1 = none).
    task automatic run_frame(input string name, input int gap, input int rst_at, input int rst_rel);
        int pulses = 0;
        int pulse_at = -1;
        bit rst_hit = 1'b0;
        bit acc;
        logic [15:0] aux16;
        acc = model_accepts();
        for (int i = 0; i < frm.size(); i++) begin
            if (i == rst_at) begin
                rst = 1'b0;
                rst_hit = 1'b1;
                #1;
                check_eq({name, " rst frame_count"}, 32'(frame_count), 32'd0);
                check_eq({name, " rst seg"}, 32'(segment_number), 32'd0);
            end
            if (i == rst_rel) rst = 1'b1;
            rx_data  = frm[i];
            rx_valid = 1'b1;
            @(posedge clk);
            #1;
            if (valid_out) begin
                pulses++;
                if (pulse_at < 0) pulse_at = i;
            end
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            if (valid_out) pulses++;
        end
        if (rst_hit) begin
            exp_frames = 0;
            exp_drops  = 0;
            exp_seg    = '0;
            exp_max    = '0;
            exp_aux    = '0;
            check_eq({name, " pulses"}, 32'(pulses), 32'd0);
        end else if (acc) begin
            exp_frames++;
            exp_seg = {frm[14], frm[15]};
            exp_max = {frm[16], frm[17]};
            aux16   = {frm[18], frm[19]};
            exp_aux = aux16[AUXB:0];
            check_eq({name, " pulses"}, 32'(pulses), 32'd1);
            check_eq({name, " pulse byte"}, 32'(pulse_at), 32'd19);
        end else begin
            exp_drops++;
            check_eq({name, " pulses"}, 32'(pulses), 32'd0);
        end
        check_eq({name, " frame_count"}, 32'(frame_count), 32'(sat16(exp_frames)));
        check_eq({name, " drop_count"}, 32'(drop_count), 32'(sat16(exp_drops)));
        check_eq({name, " seg"}, 32'(segment_number), 32'(exp_seg));
        check_eq({name, " seg_max"}, 32'(segment_number_max), 32'(exp_max));
        check_eq({name, " aux"}, 32'(aux), 32'(exp_aux));
    endtask

    initial begin
        logic [47:0] dst;
        logic [15:0] et;
        int len;
        int sel;

        #1;
        check_eq("reset seg", 32'(segment_number), 32'd0);
        check_eq("reset seg_max", 32'(segment_number_max), 32'd0);
        check_eq("reset aux", 32'(aux), 32'd0);
        check_eq("reset valid_out", 32'(valid_out), 32'd0);
        check_eq("reset frame_count", 32'(frame_count), 32'd0);
        check_eq("reset drop_count", 32'(drop_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        build_frame(64, 16'h88B5, MY_MAC, 16'h0003, 16'h0010, 16'h1005);
        run_frame("good64", 2, -1, -1);
        build_frame(64, 16'h0800, MY_MAC, 16'h0007, 16'h0008, 16'h0009);
        run_frame("type0800", 2, -1, -1);
        build_frame(15, 16'h88B5, MY_MAC, 16'h0001, 16'h0002, 16'h0003);
        run_frame("runt15", 1, -1, -1);
        build_frame(40, 16'h88B5, MY_MAC, 16'h0004, 16'h0000, 16'hFFFF);
        run_frame("auxff", 1, -1, -1);
        build_frame(20, 16'h88B5, MY_MAC, 16'h0055, 16'h0066, 16'h0077);
        run_frame("exact20", 1, -1, -1);
        build_frame(64, 16'h88B5, MY_MAC, 16'h0009, 16'h000A, 16'h000B);
        run_frame("rst_mid", 2, 16, 30);
        build_frame(64, 16'h88B5, MY_MAC, 16'h0021, 16'h0022, 16'h0023);
        run_frame("after_rst", 1, -1, -1);
        build_frame(300, 16'h88B5, BCAST, 16'h0101, 16'h0202, 16'h0303);
        run_frame("long300", 1, -1, -1);
        // Back-to-back with no idle cycle: the second header is just payload.
        build_frame(30, 16'h88B5, MY_MAC, 16'h0A0A, 16'h0B0B, 16'h0C0C);
        begin
            logic [7:0] first[$];
            first = frm;
            build_frame(30, 16'h88B5, MY_MAC, 16'h0D0D, 16'h0E0E, 16'h0F0F);
            frm = {first, frm};
        end
        run_frame("no_gap", 1, -1, -1);
`ifdef DEST_MAC_FILTER_EN
        build_frame(64, 16'h88B5, 48'h02_00_00_00_00_02, 16'h0031, 16'h0032, 16'h0033);
        run_frame("mac_other", 1, -1, -1);
        build_frame(64, 16'h88B5, BCAST, 16'h0041, 16'h0042, 16'h0043);
        run_frame("mac_bcast", 1, -1, -1);
`endif

        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 9));
            len = (sel < 2) ? int'($urandom_range(3, 22)) :
                  (sel == 9) ? int'($urandom_range(257, 320)) : int'($urandom_range(20, 80));
            et  = ($urandom_range(0, 3) != 0) ? ETYPE : 16'($urandom);
            sel = int'($urandom_range(0, 2));
            dst = (sel == 0) ? MY_MAC : (sel == 1) ? BCAST : {16'($urandom), 32'($urandom)};
            build_frame(len, et, dst, 16'($urandom), 16'($urandom), 16'($urandom));
            run_frame($sformatf("rand%0d", n), int'($urandom_range(1, 3)), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_segment_parser.md
RX_SEGMENT_PARSER -- requirements
Module: rx_segment_parser

Interface
REQ-001 The block SHALL have parameter ETHERTYPE, default 16'h88B5, the required EtherType of test frames.
REQ-002 The block SHALL have parameter AUX_BITS, default 12, where aux output width = AUX_BITS+1.
REQ-003 The block SHALL have parameter LOCAL_MAC, default 48'h02_00_00_00_00_01, the accepted destination MAC.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; every flop is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (low = reset asserted).
REQ-006 The block SHALL have port rx_data, input, 8 bits: frame byte (preamble/SFD already stripped, FCS still present).
REQ-007 The block SHALL have port rx_valid, input, 1 bit: high for every byte of one frame, contiguous; a low cycle ends the frame.
REQ-008 The block SHALL have port segment_number, output, 16 bits: frame bytes 14-15, big-endian.
REQ-009 The block SHALL have port segment_number_max, output, 16 bits: frame bytes 16-17, big-endian.
REQ-010 The block SHALL have port aux, output, AUX_BITS+1 bits: low AUX_BITS+1 bits of big-endian bytes 18-19.
REQ-011 The block SHALL have port valid_out, output, 1 bit: one-cycle pulse; the three fields are new and coherent.
REQ-012 The block SHALL have port frame_count, output, 16 bits: accepted frames.
REQ-013 The block SHALL have port drop_count, output, 16 bits: rejected frames.

Function
REQ-014 States SHALL be IDLE, HEADER, SKIP; 8-bit byte index counts accepted bytes of the current frame from 0.
REQ-015 IDLE->HEADER SHALL occur on the rx_valid rising edge; the first valid byte is index 0.
REQ-016 In HEADER, bytes 12-13 SHALL be compared with ETHERTYPE; on mismatch -> SKIP, drop_count+1 once.
REQ-017 In HEADER, bytes 14-19 SHALL load shadow registers; outputs update only on acceptance.
REQ-018 Acceptance SHALL occur when byte 19 is clocked in: outputs load, valid_out high the next cycle for exactly 1 cycle, frame_count+1, state -> SKIP.
REQ-019 SKIP SHALL ignore bytes until rx_valid is low, then -> IDLE.
REQ-020 rx_valid low in HEADER before byte 19 (runt) SHALL drop the frame: drop_count+1, no valid_out, -> IDLE.
REQ-021 Frame end SHALL need at least one low rx_valid cycle; rx_valid held high never starts a second frame.
REQ-022 Byte index SHALL saturate at 255; frames longer than 256 bytes are legal.
REQ-023 frame_count and drop_count SHALL saturate at 16'hFFFF, never wrap.
REQ-024 Bytes 18-19 bits above AUX_BITS SHALL be discarded, not checked.
REQ-025 Outputs SHALL hold their last accepted values between valid_out pulses.
REQ-026 Field values SHALL not be checked (segment_number_max = 0 passes through).

Reset
REQ-027 With rst low, all outputs and counters SHALL be 0 and state IDLE, asynchronously.
REQ-028 If rst releases while rx_valid is high, the block SHALL enter SKIP and ignore the rest of that frame, counting neither accept nor drop.

Configuration
REQ-029 With DEST_MAC_FILTER_EN defined, bytes 0-5 SHALL equal LOCAL_MAC or FF:FF:FF:FF:FF:FF, else -> SKIP with drop_count+1.
REQ-030 Without DEST_MAC_FILTER_EN, bytes 0-5 SHALL be ignored; timing is identical in both builds.

Structure
REQ-031 Package rx_parser_pkg SHALL hold the state enum, byte offsets (ETYPE_OFS=12, SEG_OFS=14, SEGMAX_OFS=16, AUX_OFS=18, HDR_LAST=19) and default ETHERTYPE.
REQ-032 Sub-module mac_filter (byte index + data in, match flag out) SHALL exist only under DEST_MAC_FILTER_EN.

Verification
REQ-033 Good 64-byte frame, type 88B5, seg=0003, max=0010, aux=0x1005 -> one valid_out 1 cycle after byte 19; outputs 3/16/0x1005; frame_count=1.
REQ-034 Same frame with type 0800 -> no valid_out; drop_count=1; outputs unchanged.
REQ-035 15-byte runt, then a good frame after a 1-cycle gap -> drop_count=1, second frame accepted, frame_count=1.
REQ-036 aux bytes 0xFF,0xFF with AUX_BITS=12 -> aux=0x1FFF.
REQ-037 Reset asserted at byte 16 and released at byte 30 of the same frame -> no valid_out, counters 0; next frame accepted.
REQ-038 DEST_MAC_FILTER_EN, dst 02:00:00:00:00:02 -> dropped; dst broadcast -> accepted.
